bus_arbiter_split: RTL
======================

// Module: bus_arbiter_split
// PURPOSE
//  Parametrised successor to the 2-master bus arbiter inside the bus interconnect. Supports N masters and
//  M slaves, with fixed-priority or round-robin selection. Adds split-transaction parking: a slave may
//  release the bus mid-transaction, and the parked master later resumes with top priority.
//  Drives grants to the master modules and arbiter_busy/bus_busy to every master.
// PARAMETERS
//  NUM_MASTERS    2    masters on the bus (2..8); ID_W = $clog2(NUM_MASTERS), min 1
//  NUM_SLAVES     3    slaves with a split_en line (1..4)
//  SLAVE_LEN      2    width of each master's slave-select field
//  RR_MODE        0    0 = fixed priority (master 0 highest); 1 = round-robin
//  SPLIT_TIMEOUT  255  cycles a master may stay parked before forced release (8-bit counter)
// PORTS
//  clk                in   1                      system clock
//  reset              in   1                      synchronous, active-high
//  request            in   NUM_MASTERS            per-master bus request; held until grant
//  slave_sel          in   NUM_MASTERS*SLAVE_LEN  master i's target slave in bits [i*SLAVE_LEN +: SLAVE_LEN]
//  trans_done         in   1                      1-cycle pulse from granted master at end of transaction
//  split_en           in   NUM_SLAVES             slave s requests/holds split while high
//  grant              out  NUM_MASTERS            one-hot grant, or all zero
//  grant_id           out  ID_W                   index of granted master; valid only when bus_busy
//  arbiter_busy       out  1                      high in every state except IDLE
//  bus_busy           out  1                      |grant
//  split_parked       out  NUM_MASTERS            master i is parked on a split slave
//  split_timeout_err  out  1                      1-cycle pulse on forced release
// BEHAVIOUR
//  Reset (sync):
//   - state = IDLE; grant, grant_id, split_parked, split_timeout_err = 0.
//   - RR pointer = 0; all timeout counters = 0.
//   - Reset mid-transaction drops grant on the next edge; any parked master is discarded.
//  Eligibility of master i:
//   - request[i] = 1, and not parked, and its target slave has no parked master.
//   - Exception: the master released from a split is eligible with its own request.
//  Release of a parked master: split_en of its parked slave is low, or its timeout counter
//  reaches SPLIT_TIMEOUT.
//  Winner selection, in priority order:
//   1. A resuming (released) master; the lowest index wins if several are released together.
//   2. RR_MODE = 0: lowest-index eligible master.
//   3. RR_MODE = 1: first eligible master at or after the RR pointer, wrapping from N-1 to 0.
//  FSM:
//   - IDLE: if any candidate, register the winner -> grant is one-hot at edge t+1 after request at t.
//     State -> BUSY.
//   - BUSY, trans_done = 1: grant drops next cycle; state -> IDLE.
//     RR pointer = winner + 1, modulo N.
//   - BUSY, split_en[slave_sel of winner] = 1, trans_done = 0: set split_parked[winner] and record
//     its slave. Grant drops next cycle; state -> IDLE. RR pointer is not advanced.
//   - BUSY, trans_done and split in the same cycle: trans_done wins; no park.
//   - IDLE -> BUSY requires at least one idle cycle between grants, so grants never overlap.
//  Parked state:
//   - The parked master's request is ignored; its counter increments every cycle while parked.
//   - Forced release at the timeout: clear park, pulse split_timeout_err, counter = 0.
//   - Normal release also clears park and resets the counter.
//  Request withdrawn: if the winner deasserts request while in BUSY with no trans_done, grant holds.
//  Only trans_done, split or reset end a tenure.
//  Out-of-range slave_sel (>= NUM_SLAVES): treated as no split; eligibility is unaffected.
// TESTING
//  1. RR_MODE=0; request=2'b11 at t -> grant=2'b01 at t+1.
//     trans_done -> grant=0, then grant=2'b10 two cycles later.
//  2. RR_MODE=1, N=4, all requesting -> grant order 0,1,2,3,0 across five tenures.
//  3. Master 0 on slave 0; split_en[0]=1 while BUSY -> split_parked=01, grant=0.
//     Master 1 on slave 1 granted next; master 1 targeting slave 0 stays blocked.
//  4. Release split_en[0] while master 1 is granted. After master 1's trans_done, master 0 is granted
//     ahead of a pending master 2.
//  5. SPLIT_TIMEOUT=4, split_en held high -> split_timeout_err pulses exactly once, 4 cycles after
//     parking; master 0 is eligible again.
//  6. trans_done and split_en in the same cycle -> no park. Assert reset while BUSY with one master
//     parked -> all outputs 0 next cycle.

Source files
------------

// File: rtl/bus_arbiter_split.sv
// bus_arbiter_split: N-master / M-slave bus arbiter with fixed-priority or
// round-robin selection and split-transaction parking with timeout release.
module bus_arbiter_split #(
  parameter int unsigned NUM_MASTERS   = 2,
  parameter int unsigned NUM_SLAVES    = 3,
  parameter int unsigned SLAVE_LEN     = 2,
  parameter int unsigned RR_MODE       = 0,
  parameter int unsigned SPLIT_TIMEOUT = 255,
  parameter int unsigned ID_W          = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_MASTERS-1:0]           request,
  input  logic [NUM_MASTERS*SLAVE_LEN-1:0] slave_sel,
  input  logic                             trans_done,
  input  logic [NUM_SLAVES-1:0]            split_en,
  output logic [NUM_MASTERS-1:0]           grant,
  output logic [ID_W-1:0]                  grant_id,
  output logic                             arbiter_busy,
  output logic                             bus_busy,
  output logic [NUM_MASTERS-1:0]           split_parked,
  output logic                             split_timeout_err
);

  localparam int unsigned CNT_W = 8;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  // Registered state
  state_t                 r_state;
  logic [NUM_MASTERS-1:0] r_grant;
  logic [ID_W-1:0]        r_grant_id;
  logic [ID_W-1:0]        r_rr_ptr;
  logic [NUM_MASTERS-1:0] r_parked;
  logic [NUM_MASTERS-1:0] r_resume;
  logic [SLAVE_LEN-1:0]   r_park_slave [NUM_MASTERS];
  logic [CNT_W-1:0]       r_cnt        [NUM_MASTERS];
  logic                   r_timeout_err;

  // Next-state values
  state_t                 w_state_nxt;
  logic [NUM_MASTERS-1:0] w_grant_nxt;
  logic [ID_W-1:0]        w_grant_id_nxt;
  logic [ID_W-1:0]        w_rr_ptr_nxt;
  logic [NUM_MASTERS-1:0] w_parked_nxt;
  logic [NUM_MASTERS-1:0] w_resume_nxt;
  logic [SLAVE_LEN-1:0]   w_park_slave_nxt [NUM_MASTERS];
  logic [CNT_W-1:0]       w_cnt_nxt        [NUM_MASTERS];
  logic                   w_timeout_err_nxt;

  // Decoded per-master / per-slave information
  logic [SLAVE_LEN-1:0]   w_sel        [NUM_MASTERS];
  logic [NUM_MASTERS-1:0] w_sel_valid;
  logic [NUM_MASTERS-1:0] w_sel_split;
  logic [NUM_MASTERS-1:0] w_sel_blocked;
  logic [NUM_MASTERS-1:0] w_park_split;
  logic [NUM_SLAVES-1:0]  w_slave_parked;
  logic                   w_cur_split;
  logic [SLAVE_LEN-1:0]   w_cur_sel;

  // Arbitration
  logic [NUM_MASTERS-1:0] w_resume_req;
  logic [NUM_MASTERS-1:0] w_elig;
  logic                   w_win_vld;
  logic [ID_W-1:0]        w_win_id;

  // Rotated index for the round-robin search, ptr + k modulo NUM_MASTERS.
  function automatic int unsigned rr_idx(input int unsigned ptr, input int unsigned k);
    int unsigned sum;
    sum = ptr + k;
    if (sum >= NUM_MASTERS) sum = sum - NUM_MASTERS;
    return sum;
  endfunction

  // Decode slave selects, parked slaves and the split request seen by the current owner.
  always_comb begin
    w_slave_parked = '0;
    w_park_split   = '0;
    w_sel_valid    = '0;
    w_sel_split    = '0;
    w_sel_blocked  = '0;
    w_cur_split    = 1'b0;
    w_cur_sel      = '0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      w_sel[i] = slave_sel[i*SLAVE_LEN +: SLAVE_LEN];
      for (int unsigned s = 0; s < NUM_SLAVES; s++) begin
        if (r_park_slave[i] == SLAVE_LEN'(s)) begin
          w_park_split[i] = split_en[s];
          if (r_parked[i]) w_slave_parked[s] = 1'b1;
        end
      end
    end
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      for (int unsigned s = 0; s < NUM_SLAVES; s++) begin
        if (w_sel[i] == SLAVE_LEN'(s)) begin
          w_sel_valid[i]   = 1'b1;
          w_sel_split[i]   = split_en[s];
          w_sel_blocked[i] = w_slave_parked[s];
        end
      end
      if (r_grant_id == ID_W'(i)) begin
        w_cur_split = w_sel_valid[i] & w_sel_split[i];
        w_cur_sel   = w_sel[i];
      end
    end
  end

  // Eligibility and winner selection: resuming masters first, then fixed or round-robin.
  always_comb begin
    w_resume_req = r_resume & request;
    w_elig       = '0;
    w_win_vld    = 1'b0;
    w_win_id     = '0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      w_elig[i] = (request[i] & ~r_parked[i] & ~w_sel_blocked[i]) | w_resume_req[i];
    end
    if (|w_resume_req) begin
      for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
        if (!w_win_vld && w_resume_req[i]) begin
          w_win_vld = 1'b1;
          w_win_id  = ID_W'(i);
        end
      end
    end else if (RR_MODE != 0) begin
      for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
        for (int unsigned j = 0; j < NUM_MASTERS; j++) begin
          if (!w_win_vld && w_elig[j] && (j == rr_idx(32'(r_rr_ptr), k))) begin
            w_win_vld = 1'b1;
            w_win_id  = ID_W'(j);
          end
        end
      end
    end else begin
      for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
        if (!w_win_vld && w_elig[i]) begin
          w_win_vld = 1'b1;
          w_win_id  = ID_W'(i);
        end
      end
    end
  end

  // Next-state logic: park aging/release, then the IDLE/BUSY tenure FSM.
  always_comb begin
    w_state_nxt       = r_state;
    w_grant_nxt       = r_grant;
    w_grant_id_nxt    = r_grant_id;
    w_rr_ptr_nxt      = r_rr_ptr;
    w_parked_nxt      = r_parked;
    w_resume_nxt      = r_resume;
    w_timeout_err_nxt = 1'b0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      w_park_slave_nxt[i] = r_park_slave[i];
      w_cnt_nxt[i]        = r_cnt[i];
    end

    // A parked master leaves park when its slave drops split or its counter times out.
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      if (r_parked[i]) begin
        if (!w_park_split[i]) begin
          w_parked_nxt[i] = 1'b0;
          w_resume_nxt[i] = 1'b1;
          w_cnt_nxt[i]    = '0;
        end else if ((r_cnt[i] + CNT_W'(1)) == CNT_W'(SPLIT_TIMEOUT)) begin
          w_parked_nxt[i]   = 1'b0;
          w_resume_nxt[i]   = 1'b1;
          w_cnt_nxt[i]      = '0;
          w_timeout_err_nxt = 1'b1;
        end else begin
          w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
        end
      end
    end

    case (r_state)
      S_IDLE: begin
        if (w_win_vld) begin
          w_state_nxt    = S_BUSY;
          w_grant_id_nxt = w_win_id;
          for (int unsigned j = 0; j < NUM_MASTERS; j++) begin
            w_grant_nxt[j] = (w_win_id == ID_W'(j));
            if (w_win_id == ID_W'(j)) w_resume_nxt[j] = 1'b0;
          end
        end
      end
      S_BUSY: begin
        // trans_done outranks a split raised in the same cycle.
        if (trans_done) begin
          w_state_nxt    = S_IDLE;
          w_grant_nxt    = '0;
          w_grant_id_nxt = '0;
          if (r_grant_id == ID_W'(NUM_MASTERS - 1)) w_rr_ptr_nxt = '0;
          else                                      w_rr_ptr_nxt = r_grant_id + ID_W'(1);
        end else if (w_cur_split) begin
          w_state_nxt    = S_IDLE;
          w_grant_nxt    = '0;
          w_grant_id_nxt = '0;
          for (int unsigned j = 0; j < NUM_MASTERS; j++) begin
            if (r_grant_id == ID_W'(j)) begin
              w_parked_nxt[j]     = 1'b1;
              w_park_slave_nxt[j] = w_cur_sel;
              w_cnt_nxt[j]        = '0;
            end
          end
        end
      end
      default: begin
        w_state_nxt    = S_IDLE;
        w_grant_nxt    = '0;
        w_grant_id_nxt = '0;
      end
    endcase
  end

  // State register with synchronous reset; reset discards any parked master.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_grant       <= '0;
      r_grant_id    <= '0;
      r_rr_ptr      <= '0;
      r_parked      <= '0;
      r_resume      <= '0;
      r_timeout_err <= 1'b0;
      for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
        r_park_slave[i] <= '0;
        r_cnt[i]        <= '0;
      end
    end else begin
      r_state       <= w_state_nxt;
      r_grant       <= w_grant_nxt;
      r_grant_id    <= w_grant_id_nxt;
      r_rr_ptr      <= w_rr_ptr_nxt;
      r_parked      <= w_parked_nxt;
      r_resume      <= w_resume_nxt;
      r_timeout_err <= w_timeout_err_nxt;
      for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
        r_park_slave[i] <= w_park_slave_nxt[i];
        r_cnt[i]        <= w_cnt_nxt[i];
      end
    end
  end

  assign grant             = r_grant;
  assign grant_id          = r_grant_id;
  assign arbiter_busy      = (r_state == S_BUSY);
  assign bus_busy          = |r_grant;
  assign split_parked      = r_parked;
  assign split_timeout_err = r_timeout_err;

endmodule
